// File: rtl/car_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | car_pkg                                                            |
// | Shared states and screen/sprite geometry for the car sequencer.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package car_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ERASE = 3'd1,
      MOVE  = 3'd2,
      DRAW  = 3'd3,
      WAIT  = 3'd4
   } car_state_t;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int SPRITE_W = 20;
   localparam int SPRITE_H = 20;

   localparam logic [7:0] X_MAX_DEF = 8'(SCREEN_W - SPRITE_W);
   localparam logic [8:0] BG_COLOUR = 9'h000;

endpackage

`default_nettype wire

// File: rtl/step_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | step_divider                                                       |
// | Counts unpaused frame ticks while enabled; pulses step every N.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module step_divider #(
   parameter int FRAMES_PER_STEP = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic en,
   input  logic pause,
   input  logic frame_tick,
   output logic step
);

   logic [3:0] r_count;
   logic       w_tick;
   logic       w_last;

   assign w_tick = en & frame_tick & ~pause;
   assign w_last = (r_count == 4'(FRAMES_PER_STEP - 1));
   assign step   = w_tick & w_last;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_count <= 4'd0;
      end else if (w_tick) begin
         r_count <= w_last ? 4'd0 : r_count + 4'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/car_move_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | car_move_ctrl                                                      |
// | Erase/move/draw/wait sequencer for the 20x20 car sprite drawer.    |
// | Optional feature macro: CAR_ERASE_EN (erase pass before each move) |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module car_move_ctrl
   import car_pkg::*;
#(
   parameter logic [7:0] X_START         = 8'd0,
   parameter logic [6:0] LANE_Y          = 7'd50,
   parameter logic [7:0] X_MAX           = X_MAX_DEF,
   parameter logic [7:0] STEP_PX         = 8'd2,
   parameter int         FRAMES_PER_STEP = 4,
   parameter logic [8:0] WDOG_CYCLES     = 9'd511
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       pause,
   input  logic       frame_tick,
   input  logic       draw_done,
   output logic [7:0] car_x,
   output logic [6:0] car_y,
   output logic       draw_resetn,
   output logic       plot,
   output logic       erase,
   output logic       lap,
   output logic       wdog_err
);

   car_state_t r_state;
   logic [8:0] r_phase;
   logic [7:0] r_car_x;
   logic       r_draw_resetn;
   logic       r_plot;
   logic       r_lap;
   logic       r_wdog_err;

   logic       w_step;
   logic       w_done_ok;
   logic       w_wdog_hit;
   logic       w_phase_end;
   logic [8:0] w_next_x;
   logic       w_wrap;

   step_divider #(
      .FRAMES_PER_STEP(FRAMES_PER_STEP)
   ) u_step_div (
      .clk       (clk),
      .resetn    (resetn),
      .en        (r_state == WAIT),
      .pause     (pause),
      .frame_tick(frame_tick),
      .step      (w_step)
   );

   // Phase 0 carries the drawer's stale done from reset, so it is never accepted.
   assign w_done_ok   = draw_done && (r_phase != 9'd0);
   assign w_wdog_hit  = !w_done_ok && (r_phase == WDOG_CYCLES);
   assign w_phase_end = w_done_ok || (r_phase == WDOG_CYCLES);

   assign w_next_x = {1'b0, r_car_x} + {1'b0, STEP_PX};
   assign w_wrap   = (w_next_x > {1'b0, X_MAX});

`ifdef CAR_ERASE_EN
   logic r_erase;
   assign erase = r_erase;
`else
   assign erase = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state       <= IDLE;
         r_phase       <= 9'd0;
         r_car_x       <= X_START;
         r_draw_resetn <= 1'b0;
         r_plot        <= 1'b0;
         r_lap         <= 1'b0;
         r_wdog_err    <= 1'b0;
`ifdef CAR_ERASE_EN
         r_erase       <= 1'b0;
`endif
      end else begin
         r_lap <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state       <= DRAW;
                  r_phase       <= 9'd0;
                  r_draw_resetn <= 1'b1;
               end
            end
`ifdef CAR_ERASE_EN
            ERASE,
`endif
            DRAW: begin
               if (w_phase_end) begin
                  r_draw_resetn <= 1'b0;
                  r_plot        <= 1'b0;
                  r_phase       <= 9'd0;
                  if (w_wdog_hit) begin
                     r_wdog_err <= 1'b1;
                  end
`ifdef CAR_ERASE_EN
                  r_erase <= 1'b0;
                  r_state <= (r_state == ERASE) ? MOVE : WAIT;
`else
                  r_state <= WAIT;
`endif
               end else begin
                  // Plot lags draw_resetn by one cycle to cover the drawer's ROM latency.
                  r_phase <= r_phase + 9'd1;
                  r_plot  <= 1'b1;
               end
            end
            MOVE: begin
               r_car_x       <= w_wrap ? X_START : w_next_x[7:0];
               r_lap         <= w_wrap;
               r_state       <= DRAW;
               r_phase       <= 9'd0;
               r_draw_resetn <= 1'b1;
            end
            WAIT: begin
               if (w_step) begin
`ifdef CAR_ERASE_EN
                  r_state       <= ERASE;
                  r_phase       <= 9'd0;
                  r_draw_resetn <= 1'b1;
                  r_erase       <= 1'b1;
`else
                  r_state <= MOVE;
`endif
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign car_x       = r_car_x;
   assign car_y       = LANE_Y;
   assign draw_resetn = r_draw_resetn;
   assign plot        = r_plot;
   assign lap         = r_lap;
   assign wdog_err    = r_wdog_err;

endmodule

`default_nettype wire

// File: doc/car_move_ctrl.md
# car_move_ctrl

Upstream sequencer for the 20x20 car sprite drawer. Each motion step erases the car at its old position, advances it along its lane, redraws it at the new position, then waits for the next step tick. It drives the drawer's origin (COUNTER_X/COUNTER_Y) and hold-in-reset line, consumes its draw_done, and produces the VGA write enable and colour-select.

## Interface
- X_START, 0: initial and wrap-to x origin (8 bit).
- LANE_Y, 50: fixed y origin of the lane (7 bit).
- X_MAX, 140: last legal x origin (160 − 20).
- STEP_PX, 2: pixels advanced per step.
- FRAMES_PER_STEP, 4: frame ticks per motion step (1..15).
- BG_COLOUR, 9'h000: colour used when erasing.
- WDOG_CYCLES, 511: maximum cycles per draw phase.

Ports:
- clk, input, 1: system clock.
- resetn, input, 1: synchronous, active-low reset.
- start, input, 1: one-cycle pulse; leaves IDLE.
- pause, input, 1: level; while high, WAIT holds and step ticks are not counted.
- frame_tick, input, 1: one-cycle pulse per 60 Hz frame.
- draw_done, input, 1: from the sprite drawer.
- car_x, output, 8: drawer COUNTER_X.
- car_y, output, 7: drawer COUNTER_Y; constant LANE_Y.
- draw_resetn, output, 1: drawer reset; low holds the drawer idle.
- plot, output, 1: VGA writeEn.
- erase, output, 1: high selects BG_COLOUR over the sprite colour in the VGA colour mux.
- lap, output, 1: one-cycle pulse on wrap.
- wdog_err, output, 1: sticky error flag.

## Operation
- States: IDLE → ERASE → MOVE → DRAW → WAIT → ERASE …
- Reset values: state=IDLE, car_x=X_START, draw_resetn=0, plot=0, erase=0, lap=0, wdog_err=0, phase and frame counters=0.
- IDLE: waits for start. On start, goes to DRAW so the first pass skips the erase.
- ERASE and DRAW (draw phases):
  - draw_resetn=1; erase=1 only in ERASE.
  - Phase counter clears on entry.
  - draw_done is accepted only when the phase counter ≥ 1, which masks the stale done left over from the drawer's reset.
  - plot=1 from phase counter ≥ 1 through the cycle done is accepted, compensating for the drawer's one-cycle ROM latency.
  - When done is accepted, the next state is entered and draw_resetn returns to 0.
- Watchdog: if the phase counter reaches WDOG_CYCLES, the phase ends as if done, and wdog_err is set. wdog_err is cleared only by resetn.
- MOVE: one cycle.
  - If car_x + STEP_PX > X_MAX (9-bit compare, no 8-bit overflow), car_x ← X_START and lap pulses.
  - Otherwise car_x ← car_x + STEP_PX.
- WAIT:
  - The frame counter increments on each frame_tick while pause=0.
  - When it reaches FRAMES_PER_STEP, it clears and the next state is ERASE.
  - frame_tick arriving in any other state is ignored.
- start outside IDLE is ignored.
- resetn low in any state, including mid-draw, returns all outputs to their reset values on the next edge.

## Timing
- A draw phase lasts 402 cycles with the current drawer: 1 masked cycle, 400 pixels, 1 done cycle. plot is high for 401 of them.
- Steady-state step: ERASE (402) + MOVE (1) + DRAW (402) + WAIT (≥ 1).
- car_x changes only at the MOVE clock edge; it is stable throughout every draw phase.
- lap is high during the first DRAW cycle after a wrap.

## Configuration
- CAR_ERASE_EN:
  - Defined: behaviour as above.
  - Undefined: the ERASE state is removed, WAIT goes directly to MOVE, erase is tied to 0, and the sprite leaves a trail.

## Structure
- Shared package car_pkg:
  - State enum: IDLE, ERASE, MOVE, DRAW, WAIT.
  - SCREEN_W=160, SCREEN_H=120, SPRITE_W=20, SPRITE_H=20.
  - X_MAX is derived as SCREEN_W − SPRITE_W.
- Sub-module step_divider: counts frame_tick with pause gating and outputs a one-cycle step pulse; it is enabled only in WAIT.

## Test plan
1. Reset, then start. DRAW begins with car_x=0 and car_y=50, with no ERASE first. plot rises one cycle after draw_resetn rises. Exactly 401 plot cycles occur, then WAIT.
2. Apply 4 frame_ticks. Sequence is ERASE (erase=1, 401 plots at x=0), then MOVE, then DRAW at x=2.
3. Preload car_x=140 with STEP_PX=2. MOVE gives car_x=0 and lap pulses once.
4. Hold pause for 10 frame_ticks. The FSM stays in WAIT. After release, the next 4 ticks trigger ERASE.
5. Tie draw_done=0. After 511 cycles in DRAW, wdog_err=1 and WAIT is entered. wdog_err survives further steps.
6. Assert resetn low mid-DRAW at phase count 200. Next edge: IDLE, plot=0, draw_resetn=0, car_x=0. With CAR_ERASE_EN undefined, no ERASE state is ever entered.
